// File: rtl/bomb_lifecycle_ctrl.sv
// rtl/bomb_lifecycle_ctrl.sv - single-bomb placement, fuse, explosion and cooldown sequencer
//
// Purpose:
//   Tracks one bomb through the IDLE -> ARMED -> EXPLODING -> COOLDOWN -> IDLE cycle.
//   All timing is counted in video frames (startOfFrame pulses).
//   Every output is registered.
//
// Optional feature (macro CHAIN_DETONATION_EN):
//   When defined, chain_hit while ARMED detonates the bomb on the next cycle.
//   Chain detonation takes priority over a coincident frame pulse.
//   When undefined, chain_hit is ignored.
//
// Ports:
//   clk            in   1  single clock
//   resetN         in   1  synchronous active-low reset
//   startOfFrame   in   1  one-cycle pulse per video frame
//   place_req      in   1  one-cycle placement request
//   player_col     in   5  player tile column
//   player_row     in   4  player tile row
//   chain_hit      in   1  another explosion covers this bomb
//   bomb_exist     out  1  bomb present (ARMED or EXPLODING)
//   bomb_exploded  out  1  explosion active
//   direction      out  1  explosion animation frame select
//   bomb_col       out  5  latched bomb column
//   bomb_row       out  4  latched bomb row
//   fuse_remaining out  8  fuse frames left
//   place_reject   out  1  one-cycle pulse on a refused request
//   explode_done   out  1  one-cycle pulse when the explosion ends

module bomb_lifecycle_ctrl #(
  parameter int unsigned FUSE_FRAMES     = 120,
  parameter int unsigned EXPLODE_FRAMES  = 30,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       place_req,
  input  logic [4:0] player_col,
  input  logic [3:0] player_row,
  input  logic       chain_hit,
  output logic       bomb_exist,
  output logic       bomb_exploded,
  output logic       direction,
  output logic [4:0] bomb_col,
  output logic [3:0] bomb_row,
  output logic [7:0] fuse_remaining,
  output logic       place_reject,
  output logic       explode_done
);

  localparam logic [7:0] FUSE_LOAD = 8'(FUSE_FRAMES);
  localparam logic [7:0] EXPL_LOAD = 8'(EXPLODE_FRAMES);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    EXPLODING = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] expl_cnt, expl_cnt_nxt;
  logic [7:0] cool_cnt, cool_cnt_nxt;
  logic [1:0] dir_sub, dir_sub_nxt;
  logic [7:0] fuse_nxt;
  logic [4:0] col_nxt;
  logic [3:0] row_nxt;
  logic       exist_nxt, exploded_nxt, dir_nxt, reject_nxt, done_nxt;
  logic       chain_fire;

`ifdef CHAIN_DETONATION_EN
  assign chain_fire = chain_hit;
`else
  logic chain_hit_unused;
  assign chain_hit_unused = chain_hit;
  assign chain_fire       = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    expl_cnt_nxt = expl_cnt;
    cool_cnt_nxt = cool_cnt;
    dir_sub_nxt  = dir_sub;
    fuse_nxt     = fuse_remaining;
    col_nxt      = bomb_col;
    row_nxt      = bomb_row;
    exist_nxt    = bomb_exist;
    exploded_nxt = bomb_exploded;
    dir_nxt      = direction;
    done_nxt     = 1'b0;
    // Requests outside IDLE are refused; coordinates stay untouched.
    reject_nxt   = place_req && (state != IDLE);

    unique case (state)
      IDLE: begin
        // A coincident frame pulse is deliberately not charged to the new fuse.
        if (place_req) begin
          state_nxt = ARMED;
          exist_nxt = 1'b1;
          col_nxt   = player_col;
          row_nxt   = player_row;
          fuse_nxt  = FUSE_LOAD;
        end
      end

      ARMED: begin
        if (chain_fire || (startOfFrame && fuse_remaining <= 8'd1)) begin
          state_nxt    = EXPLODING;
          fuse_nxt     = 8'd0;
          exist_nxt    = 1'b1;
          exploded_nxt = 1'b1;
          dir_nxt      = 1'b0;
          dir_sub_nxt  = 2'd0;
          expl_cnt_nxt = EXPL_LOAD;
        end else if (startOfFrame) begin
          fuse_nxt = fuse_remaining - 8'd1;
        end
      end

      EXPLODING: begin
        if (startOfFrame) begin
          if (expl_cnt <= 8'd1) begin
            state_nxt    = COOLDOWN;
            expl_cnt_nxt = 8'd0;
            exist_nxt    = 1'b0;
            exploded_nxt = 1'b0;
            dir_nxt      = 1'b0;
            done_nxt     = 1'b1;
            cool_cnt_nxt = COOL_LOAD;
          end else begin
            expl_cnt_nxt = expl_cnt - 8'd1;
            dir_sub_nxt  = 2'(dir_sub + 2'd1);
            // Sub-counter wrapping from 3 marks every 4th frame of the explosion.
            if (dir_sub == 2'd3) begin
              dir_nxt = ~direction;
            end
          end
        end
      end

      COOLDOWN: begin
        if (startOfFrame) begin
          if (cool_cnt <= 8'd1) begin
            state_nxt    = IDLE;
            cool_cnt_nxt = 8'd0;
          end else begin
            cool_cnt_nxt = cool_cnt - 8'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      expl_cnt       <= 8'd0;
      cool_cnt       <= 8'd0;
      dir_sub        <= 2'd0;
      fuse_remaining <= 8'd0;
      bomb_col       <= 5'd0;
      bomb_row       <= 4'd0;
      bomb_exist     <= 1'b0;
      bomb_exploded  <= 1'b0;
      direction      <= 1'b0;
      place_reject   <= 1'b0;
      explode_done   <= 1'b0;
    end else begin
      state          <= state_nxt;
      expl_cnt       <= expl_cnt_nxt;
      cool_cnt       <= cool_cnt_nxt;
      dir_sub        <= dir_sub_nxt;
      fuse_remaining <= fuse_nxt;
      bomb_col       <= col_nxt;
      bomb_row       <= row_nxt;
      bomb_exist     <= exist_nxt;
      bomb_exploded  <= exploded_nxt;
      direction      <= dir_nxt;
      place_reject   <= reject_nxt;
      explode_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bomb_lifecycle_ctrl.sv
// tb/tb_bomb_lifecycle_ctrl.sv - self-checking bench for bomb_lifecycle_ctrl

module tb_bomb_lifecycle_ctrl;

  localparam int FUSE = 3;
  localparam int EXPL = 8;
  localparam int COOL = 2;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, place_req, chain_hit;
  logic [4:0] player_col;
  logic [3:0] player_row;
  logic       bomb_exist, bomb_exploded, direction, place_reject, explode_done;
  logic [4:0] bomb_col;
  logic [3:0] bomb_row;
  logic [7:0] fuse_remaining;

  bomb_lifecycle_ctrl #(
    .FUSE_FRAMES(FUSE), .EXPLODE_FRAMES(EXPL), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .place_req(place_req),
    .player_col(player_col), .player_row(player_row), .chain_hit(chain_hit),
    .bomb_exist(bomb_exist), .bomb_exploded(bomb_exploded), .direction(direction),
    .bomb_col(bomb_col), .bomb_row(bomb_row), .fuse_remaining(fuse_remaining),
    .place_reject(place_reject), .explode_done(explode_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: a bomb is described by frames elapsed since placement and the elapsed
  // frame at which its explosion began; every phase follows from that arithmetic.
  bit m_active = 0;
  int m_el     = 0;
  int m_start  = FUSE;
  int m_col    = 0;
  int m_row    = 0;
  bit m_reject = 0;
  bit m_done   = 0;

  // 0 idle, 1 armed, 2 exploding, 3 cooldown
  function automatic int phase();
    if (!m_active) return 0;
    if (m_el < m_start) return 1;
    if (m_el < m_start + EXPL) return 2;
    if (m_el < m_start + EXPL + COOL) return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update(input bit r, input bit p, input bit s,
                              input int col, input int row, input bit ch);
    int  old;
    bit  chained;
    if (!r) begin
      m_active = 0; m_el = 0; m_col = 0; m_row = 0; m_reject = 0; m_done = 0;
    end else begin
      old      = phase();
      m_reject = p && (old != 0);
      m_done   = 0;
      chained  = 0;
      if (old == 0) begin
        m_active = 0;
        if (p) begin
          m_active = 1; m_el = 0; m_start = FUSE; m_col = col; m_row = row;
        end
      end else begin
`ifdef CHAIN_DETONATION_EN
        if (old == 1 && ch) begin
          m_start = m_el;
          chained = 1;
        end
`endif
        if (!chained && s) m_el++;
        m_done = (old == 2) && (phase() == 3);
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    ph = phase();
    chk("bomb_exist", bomb_exist, (ph == 1 || ph == 2) ? 1 : 0);
    chk("bomb_exploded", bomb_exploded, (ph == 2) ? 1 : 0);
    chk("direction", direction, (ph == 2) ? (((m_el - m_start) / 4) % 2) : 0);
    chk("fuse_remaining", fuse_remaining, (ph == 1) ? (FUSE - m_el) : 0);
    chk("bomb_col", bomb_col, m_col);
    chk("bomb_row", bomb_row, m_row);
    chk("place_reject", place_reject, m_reject);
    chk("explode_done", explode_done, m_done);
    chk("exploded_implies_exist", (bomb_exploded && !bomb_exist) ? 1 : 0, 0);
  endtask

  task automatic step(input bit r, input bit p, input bit s,
                      input int col, input int row, input bit ch);
    resetN       = r;
    place_req    = p;
    startOfFrame = s;
    player_col   = 5'(col);
    player_row   = 4'(row);
    chain_hit    = ch;
    @(posedge clk);
    model_update(r, p, s, col, row, ch);
    #1;
    compare_all();
  endtask

  task automatic frame();
    step(1, 0, 1, 0, 0, 0);
  endtask

  task automatic idle_cyc();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 9, 9, 0);
    chk("reset_exist", bomb_exist, 0);
    chk("reset_fuse", fuse_remaining, 0);
    chk("reset_col", bomb_col, 0);
    chk("reset_req_discarded", bomb_exist, 0);

    // Placement
    step(1, 1, 0, 7, 4, 0);
    chk("place_exist", bomb_exist, 1);
    chk("place_fuse3", fuse_remaining, 3);
    chk("place_col", bomb_col, 7);
    chk("place_row", bomb_row, 4);
    frame();
    chk("fuse2", fuse_remaining, 2);

    // Rejection while armed
    step(1, 1, 0, 1, 9, 0);
    chk("reject_pulse", place_reject, 1);
    chk("reject_col_held", bomb_col, 7);
    chk("reject_fuse_held", fuse_remaining, 2);
    idle_cyc();
    chk("reject_one_cycle", place_reject, 0);
    frame();
    chk("fuse1", fuse_remaining, 1);
    frame();
    chk("exploded", bomb_exploded, 1);
    chk("explode_fuse0", fuse_remaining, 0);
    chk("explode_dir0", direction, 0);

    // Explosion
    for (int i = 1; i <= EXPL; i++) begin
      frame();
      if (i < 4)       chk("dir_before4", direction, 0);
      else if (i < 8)  chk("dir_after4", direction, 1);
      else begin
        chk("done_pulse", explode_done, 1);
        chk("end_exist", bomb_exist, 0);
        chk("end_exploded", bomb_exploded, 0);
        chk("end_dir", direction, 0);
        chk("cool_col_held", bomb_col, 7);
      end
    end
    idle_cyc();
    chk("done_one_cycle", explode_done, 0);
    frame();
    frame();

    // Coincident place + frame in IDLE
    step(1, 1, 1, 3, 2, 0);
    chk("coincident_fuse3", fuse_remaining, 3);
    chk("coincident_exist", bomb_exist, 1);
    frame();
    chk("fuse2_before_chain", fuse_remaining, 2);

    // Chain hit while armed with fuse 2
    step(1, 0, 0, 0, 0, 1);
`ifdef CHAIN_DETONATION_EN
    chk("chain_exploded", bomb_exploded, 1);
    chk("chain_fuse0", fuse_remaining, 0);
`else
    chk("chain_ignored", bomb_exploded, 0);
    chk("chain_fuse_held", fuse_remaining, 2);
`endif
    frame();
    frame();
    chk("exploding_before_reset", bomb_exploded, 1);

    // Reset mid-explosion, then immediate placement
    step(0, 1, 1, 8, 8, 0);
    chk("midreset_exist", bomb_exist, 0);
    chk("midreset_exploded", bomb_exploded, 0);
    chk("midreset_col", bomb_col, 0);
    step(1, 1, 0, 5, 6, 0);
    chk("post_reset_exist", bomb_exist, 1);
    chk("post_reset_fuse", fuse_remaining, 3);
    chk("post_reset_col", bomb_col, 5);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 31)),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
